foo_result_buffer: RTL and testbench

Downstream consumer for the `foo` pipeline (valid-only, no backpressure). It captures every `out`/`output_valid` result into a small FIFO and presents it to the next block over a ready/valid handshake. It tracks results already in flight inside `foo` and issues credits upstream through `issue_ready`, so the producer can never launch a result that has no buffer slot. `foo` itself therefore stays stall-free.

---
 rtl/foo_result_buffer_pkg.sv | 13 +
 rtl/foo_credit_counter.sv | 58 +++++
 rtl/foo_result_buffer.sv | 91 +++++++++
 tb/tb_foo_result_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/foo_result_buffer_pkg.sv
// Shared constants and helpers for the foo result buffer.
// Imported by the credit counter and the buffer top.
package foo_result_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;
    localparam int FOO_LATENCY    = 1;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/foo_credit_counter.sv
// Occupancy and in-flight accounting for the foo result buffer.
// Credits are derived from registered counts only.
module foo_credit_counter
    import foo_result_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW = count_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          pipe_valid,
    input  logic          push,
    input  logic          pop,
    output logic          issue_ready,
    output logic [CW-1:0] occ,
    output logic [CW-1:0] inflight
);

    logic [CW-1:0] occ_nxt;
    logic [CW-1:0] inflight_nxt;
    logic [CW:0]   credit_sum;
    logic          issue_acc;

    assign credit_sum  = {1'b0, occ} + {1'b0, inflight};
    assign issue_ready = credit_sum < (CW + 1)'(DEPTH);
    assign issue_acc   = issue & issue_ready;

    always_comb begin
        inflight_nxt = inflight;
        // A returning result with nothing in flight is an error; clamp at 0.
        if (issue_acc && !pipe_valid) begin
            inflight_nxt = inflight + CW'(1);
        end else if (!issue_acc && pipe_valid && inflight != '0) begin
            inflight_nxt = inflight - CW'(1);
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + CW'(1);
            2'b01:   occ_nxt = occ - CW'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            inflight <= '0;
        end else begin
            occ      <= occ_nxt;
            inflight <= inflight_nxt;
        end
    end

endmodule

// File: rtl/foo_result_buffer.sv
// Captures foo results into a small FIFO and hands them on over ready/valid.
// Issues credits upstream so foo never produces a result without a slot.
module foo_result_buffer
    import foo_result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    input  logic                  pipe_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    if (DEPTH < 2 || DEPTH < FOO_LATENCY + 1) begin : g_bad_depth
        $error("foo_result_buffer: DEPTH too small for foo latency");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         occ;
    logic [CW-1:0]         inflight;
    logic                  occ_full;
    logic                  push;
    logic                  pop;

    assign occ_full  = occ == CW'(DEPTH);
    assign out_valid = occ != '0;
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push      = pipe_valid & (~occ_full | pop);
    assign out_data  = mem[rptr];

    foo_credit_counter #(
        .DEPTH(DEPTH)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .pipe_valid (pipe_valid),
        .push       (push),
        .pop        (pop),
        .issue_ready(issue_ready),
        .occ        (occ),
        .inflight   (inflight)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= pipe_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            if (pipe_valid && !push) begin
                err_overflow <= 1'b1;
            end
            if (pipe_valid && inflight == '0) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_foo_result_buffer.sv
// Scoreboard bench for foo_result_buffer with a one-cycle foo model (out = x + 2).
module tb_foo_result_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue = 1'b0;
    logic        issue_ready;
    logic [31:0] pipe_data;
    logic        pipe_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_overflow;
    logic        err_underflow;

    logic [31:0] x = '0;
    logic        foo_v;
    logic [31:0] foo_d;
    logic        force_pv = 1'b0;
    logic [31:0] force_d = '0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    foo_result_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .issue_ready  (issue_ready),
        .pipe_data    (pipe_data),
        .pipe_valid   (pipe_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foo_v <= 1'b0;
            foo_d <= '0;
        end else begin
            foo_v <= issue && issue_ready;
            foo_d <= x + 32'd2;
        end
    end

    assign pipe_valid = foo_v | force_pv;
    assign pipe_data  = force_pv ? force_d : foo_d;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected none", out_data);
            end else begin
                check("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_flow(input string tag);
        out_ready = 1'b0;
        issue = 1'b1;
        x = 32'd5;
        exp_q.push_back(32'h0000_0007);
        tick();
        issue = 1'b0;
        check({tag, "_nobypass"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_credit"}, {31'd0, issue_ready}, 32'd1);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, 32'd7);
        out_ready = 1'b1;
        tick();
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    logic [31:0] bp_x   [4] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2};
    logic [31:0] bp_exp [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] wrap_exp [10] = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h54,
                                   32'h65, 32'h76, 32'h87, 32'h98, 32'hA9};

    initial begin
        int n;
        int gaps;
        int drops;

        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_err_ovf", {31'd0, err_overflow}, 32'd0);
        check("rst_err_udf", {31'd0, err_underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        single_flow("sf");

        // Backpressure fill: four issues exhaust credit before results drain.
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1;
            x = bp_x[i];
            exp_q.push_back(bp_exp[i]);
            tick();
        end
        check("bp_no_credit", {31'd0, issue_ready}, 32'd0);
        x = 32'd100;
        tick();
        issue = 1'b0;
        tick();
        tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_still_no_credit", {31'd0, issue_ready}, 32'd0);
        check("bp_occ_full", 32'(dut.occ), 32'd4);
        check("bp_no_ovf", {31'd0, err_overflow}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("bp_credit_back", {31'd0, issue_ready}, 32'd1);
        tick();
        tick();
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;

        // Push and pop together at occ=3, then stream across pointer wrap.
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 5) begin
                check("wrap_occ3", 32'(dut.occ), 32'd3);
                check("wrap_no_ovf", {31'd0, err_overflow}, 32'd0);
            end
            if (n == 10 && exp_q.size() == 0 && !out_valid) break;
            out_ready = (n >= 4);
            issue = (n < 10) && issue_ready;
            if (issue) begin
                x = wrap_exp[n] - 32'd2;
                exp_q.push_back(wrap_exp[n]);
                n++;
            end
            tick();
        end
        issue = 1'b0;
        check("wrap_all_issued", 32'(n), 32'd10);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Streaming: one issue per cycle, output every cycle.
        out_ready = 1'b1;
        gaps = 0;
        drops = 0;
        for (int c = 0; c < 22; c++) begin
            if (c >= 2 && !out_valid) gaps++;
            if (!issue_ready) drops++;
            issue = (c < 20);
            if (issue) begin
                x = 32'(c) * 32'd3;
                exp_q.push_back(32'(c) * 32'd3 + 32'd2);
            end
            tick();
        end
        issue = 1'b0;
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_drops", 32'(drops), 32'd0);
        tick();
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Error paths: unsolicited results, then fill and overflow.
        out_ready = 1'b0;
        force_pv = 1'b1;
        force_d = 32'hAA;
        exp_q.push_back(32'hAA);
        tick();
        force_pv = 1'b0;
        check("udf_set", {31'd0, err_underflow}, 32'd1);
        check("udf_write", {31'd0, out_valid}, 32'd1);
        tick();
        tick();
        check("udf_sticky", {31'd0, err_underflow}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            force_pv = 1'b1;
            force_d = 32'hB0 + 32'(i);
            exp_q.push_back(32'hB0 + 32'(i));
            tick();
        end
        force_pv = 1'b1;
        force_d = 32'hBEEF;
        exp_q.push_back(32'hBEEF);
        out_ready = 1'b1;
        tick();
        check("full_pushpop_occ", 32'(dut.occ), 32'd4);
        check("full_pushpop_no_ovf", {31'd0, err_overflow}, 32'd0);
        out_ready = 1'b0;
        force_d = 32'hDEAD;
        tick();
        force_pv = 1'b0;
        check("ovf_set", {31'd0, err_overflow}, 32'd1);
        check("ovf_occ", 32'(dut.occ), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("err_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", {31'd0, err_overflow}, 32'd1);
        out_ready = 1'b0;

        // Async reset with occ=2, inflight=1.
        issue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 32'h40 + 32'(i);
            tick();
        end
        issue = 1'b0;
        check("pre_rst_occ", 32'(dut.occ), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_issue_ready", {31'd0, issue_ready}, 32'd1);
        check("arst_err_ovf", {31'd0, err_overflow}, 32'd0);
        check("arst_err_udf", {31'd0, err_underflow}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        single_flow("post_rst");
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
